// File: rtl/pvr_pcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pvr_pcache_pkg
// Description : Shared definitions for the primitive parameter cache.
//               - rec_words(): number of 32-bit words in one cached record
//                 (header words followed by all vertex attribute words)
//               - header word indices within a record
//               - attribute word offsets within one vertex
// Revision    : 1.0 - initial release
// ============================================================================
package pvr_pcache_pkg;

    // Header word indices (record word k = header word k for k < HDR)
    localparam int HDR_ISP = 0;
    localparam int HDR_TSP = 1;
    localparam int HDR_TCW = 2;

    // Attribute offsets inside one vertex; vertex v, attribute a lives at
    // record word HDR + v*VATTR + a.
    localparam int VA_X        = 0;
    localparam int VA_Y        = 1;
    localparam int VA_Z        = 2;
    localparam int VA_U0       = 3;
    localparam int VA_V0       = 4;
    localparam int VA_BASE_COL = 5;
    localparam int VA_OFF_COL  = 6;

    function automatic int rec_words(input int hdr, input int verts, input int vattr);
        return hdr + verts * vattr;
    endfunction

endpackage : pvr_pcache_pkg
`default_nettype wire

// File: rtl/pcache_bank.sv
`default_nettype none
// ============================================================================
// Module      : pcache_bank
// Description : One record-word column of the parameter cache: a simple
//               dual-port RAM (one write port, one read port) with a
//               registered read. Read-during-write to the same address
//               returns the old contents. Contents are never reset.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (output register holds otherwise)
//               i_raddr  - read address
//               o_rdata  - read data, valid one cycle after i_re
// Revision    : 1.0 - initial release
// ============================================================================
module pcache_bank
    import pvr_pcache_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_depth-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : pcache_bank
`default_nettype wire

// File: rtl/prim_param_cache.sv
`default_nettype none
// ============================================================================
// Module      : prim_param_cache
// Description : Tag-indexed cache of primitive parameter records. A record is
//               streamed in one 32-bit word per accepted beat (wr_last marks
//               the final word) and becomes readable only once it has been
//               committed with exactly REC_WORDS words. Reads are pipelined,
//               one per cycle, two-cycle latency, returning the whole record.
//               An invalidate request sweeps every valid bit, one per cycle.
// Ports       : clock, reset_n (synchronous, active-low)
//               wr_valid/wr_ready/wr_tag/wr_data/wr_last - record write stream
//               rd_valid/rd_ready/rd_tag                 - read request
//               rd_out_valid/rd_hit/rd_rec               - read response
//               inv_start/inv_busy                       - invalidate sweep
//               err_len                                  - malformed record pulse
// Options     : PCACHE_BYPASS_EN - when defined, a read accepted in the same
//               cycle as a commit to the same tag returns the new record
//               (final word forwarded from wr_data) with rd_hit=1.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_param_cache
    import pvr_pcache_pkg::*;
#(
    parameter int TAG_W = 12,
    parameter int VERTS = 3,
    parameter int VATTR = 7,
    parameter int HDR   = 3
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         wr_valid,
    output logic                                         wr_ready,
    input  logic [TAG_W-1:0]                             wr_tag,
    input  logic [31:0]                                  wr_data,
    input  logic                                         wr_last,
    input  logic                                         rd_valid,
    output logic                                         rd_ready,
    input  logic [TAG_W-1:0]                             rd_tag,
    output logic                                         rd_out_valid,
    output logic                                         rd_hit,
    output logic [32*rec_words(HDR, VERTS, VATTR)-1:0]   rd_rec,
    input  logic                                         inv_start,
    output logic                                         inv_busy,
    output logic                                         err_len
);

    localparam int REC_WORDS = rec_words(HDR, VERTS, VATTR);
    localparam int DEPTH     = 1 << TAG_W;
    localparam int CNT_W     = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(REC_WORDS - 1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] INV    = 2'd2;

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    logic [1:0]       r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_discard, w_discard_nxt;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_sweep;
    logic             r_inv_busy;
    logic             r_ready;
    logic             r_err_len;
    logic [DEPTH-1:0] r_valid;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_first;
    logic             w_abort;
    logic [CNT_W-1:0] w_idx;
    logic [TAG_W-1:0] w_cur_tag;
    logic             w_commit;
    logic             w_err;
    logic             w_word_we;
    logic             w_clr_first;

    assign w_wr_acc  = wr_valid && r_ready;
    assign w_rd_acc  = rd_valid && r_ready;
    assign w_first   = (r_state == W_IDLE);
    assign w_abort   = inv_start && (r_state != INV);
    // Word 0 arrives in W_IDLE, so the counter only matters once filling.
    assign w_idx     = w_first ? '0 : r_cnt;
    assign w_cur_tag = w_first ? wr_tag : r_tag;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_discard_nxt = r_discard;
        w_commit      = 1'b0;
        w_err         = 1'b0;
        w_word_we     = 1'b0;
        w_clr_first   = 1'b0;
        case (r_state)
            INV: begin
                if (r_sweep == '1) begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_IDLE, W_FILL: begin
                if (w_abort) begin
                    // Invalidate wins over any word offered this cycle.
                    w_state_nxt   = INV;
                    w_cnt_nxt     = '0;
                    w_discard_nxt = 1'b0;
                end else if (w_wr_acc) begin
                    if (r_discard) begin
                        // Overrun record: swallow words until its end.
                        if (wr_last) begin
                            w_state_nxt   = W_IDLE;
                            w_cnt_nxt     = '0;
                            w_discard_nxt = 1'b0;
                        end
                    end else begin
                        w_word_we   = 1'b1;
                        w_clr_first = w_first;
                        if (wr_last) begin
                            if (w_idx == c_last_idx) begin
                                w_commit = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                            w_state_nxt = W_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (w_idx == c_last_idx) begin
                            w_err         = 1'b1;
                            w_discard_nxt = 1'b1;
                            w_state_nxt   = W_FILL;
                            w_cnt_nxt     = '0;
                        end else begin
                            w_state_nxt = W_FILL;
                            w_cnt_nxt   = w_idx + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = INV;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= INV;
            r_cnt      <= '0;
            r_discard  <= 1'b0;
            r_sweep    <= '0;
            r_inv_busy <= 1'b1;
            r_ready    <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_discard  <= w_discard_nxt;
            // Sweep index restarts at 0 on every entry into INV and wraps
            // back to 0 on exit.
            r_sweep    <= (r_state == INV) ? r_sweep + 1'b1 : '0;
            // Busy/ready follow the next state so both are plain flops.
            r_inv_busy <= (w_state_nxt == INV);
            r_ready    <= (w_state_nxt != INV);
            r_err_len  <= w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_acc && w_first) begin
            r_tag <= wr_tag;
        end
    end

    // Valid bits are not reset directly; reset enters the sweep instead.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (r_state == INV) begin
                r_valid[r_sweep] <= 1'b0;
            end else if (w_commit) begin
                r_valid[w_cur_tag] <= 1'b1;
            end else if (w_clr_first) begin
                r_valid[wr_tag] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record storage: one RAM column per record word
    // ------------------------------------------------------------------
    logic [32*REC_WORDS-1:0] w_bank_rec;

    for (genvar k = 0; k < REC_WORDS; k++) begin : g_bank
        pcache_bank #(
            .ADDR_W (TAG_W),
            .DATA_W (32)
        ) u_bank (
            .clk     (clock),
            .i_we    (w_word_we && (w_idx == CNT_W'(k))),
            .i_waddr (w_cur_tag),
            .i_wdata (wr_data),
            .i_re    (w_rd_acc),
            .i_raddr (rd_tag),
            .o_rdata (w_bank_rec[32*k +: 32])
        );
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 = RAM access, stage 2 = output register
    // ------------------------------------------------------------------
    logic                    r_p1_vld;
    logic                    r_p1_hit;
    logic                    r_out_vld;
    logic                    r_hit;
    logic [32*REC_WORDS-1:0] r_rec;
    logic [32*REC_WORDS-1:0] w_rec_fwd;

`ifdef PCACHE_BYPASS_EN
    logic        w_byp;
    logic        r_p1_byp;
    logic [31:0] r_p1_word;

    assign w_byp = w_rd_acc && w_commit && (rd_tag == w_cur_tag);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_p1_byp <= 1'b0;
        end else begin
            r_p1_byp <= w_byp;
        end
    end

    always_ff @(posedge clock) begin
        if (w_byp) begin
            r_p1_word <= wr_data;
        end
    end

    // The committing word is being written as the RAM reads, so its column
    // still holds the old value; substitute the captured write data.
    always_comb begin
        w_rec_fwd = w_bank_rec;
        if (r_p1_byp) begin
            w_rec_fwd[32*(REC_WORDS-1) +: 32] = r_p1_word;
        end
    end
`else
    assign w_rec_fwd = w_bank_rec;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_p1_vld  <= 1'b0;
            r_p1_hit  <= 1'b0;
            r_out_vld <= 1'b0;
            r_hit     <= 1'b0;
            r_rec     <= '0;
        end else begin
            r_p1_vld  <= w_rd_acc;
`ifdef PCACHE_BYPASS_EN
            r_p1_hit  <= w_rd_acc && (r_valid[rd_tag] || w_byp);
`else
            r_p1_hit  <= w_rd_acc && r_valid[rd_tag];
`endif
            r_out_vld <= r_p1_vld;
            r_hit     <= r_p1_hit;
            if (r_p1_vld) begin
                r_rec <= w_rec_fwd;
            end
        end
    end

    assign wr_ready     = r_ready;
    assign rd_ready     = r_ready;
    assign inv_busy     = r_inv_busy;
    assign err_len      = r_err_len;
    assign rd_out_valid = r_out_vld;
    assign rd_hit       = r_hit;
    assign rd_rec       = r_rec;

endmodule : prim_param_cache
`default_nettype wire

// File: tb/tb_prim_param_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_prim_param_cache
// Description : Self-checking bench for prim_param_cache (TAG_W=4, default
//               record geometry of 24 words). A record-level reference model
//               tracks which tags hold committed records, the busy window of
//               invalidate sweeps, expected err_len pulses and the expected
//               read responses two cycles after acceptance.
//               Honours PCACHE_BYPASS_EN for the same-cycle commit/read case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prim_param_cache;

    localparam int TW    = 4;
    localparam int DEPTH = 1 << TW;
    localparam int RW    = 24;
    localparam int RB    = 32 * RW;

    typedef logic [RB-1:0] wide_t;
    typedef struct packed {
        logic  v;
        logic  hit;
        wide_t rec;
    } rd_t;

    logic            clock;
    logic            reset_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [TW-1:0]   wr_tag;
    logic [31:0]     wr_data;
    logic            wr_last;
    logic            rd_valid;
    logic            rd_ready;
    logic [TW-1:0]   rd_tag;
    logic            rd_out_valid;
    logic            rd_hit;
    logic [RB-1:0]   rd_rec;
    logic            inv_start;
    logic            inv_busy;
    logic            err_len;

    prim_param_cache #(
        .TAG_W (TW),
        .VERTS (3),
        .VATTR (7),
        .HDR   (3)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_tag       (wr_tag),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_tag       (rd_tag),
        .rd_out_valid (rd_out_valid),
        .rd_hit       (rd_hit),
        .rd_rec       (rd_rec),
        .inv_start    (inv_start),
        .inv_busy     (inv_busy),
        .err_len      (err_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (record level)
    // ------------------------------------------------------------------
    bit          m_valid [DEPTH];
    wide_t       m_rec   [DEPTH];
    int          m_busy_left;
    bit          m_inprog;
    bit          m_drop;
    logic [TW-1:0] m_tag;
    logic [31:0] m_words [$];
    rd_t         p1, p2;

    task automatic model_reset();
        m_busy_left = DEPTH;
        m_inprog    = 1'b0;
        m_drop      = 1'b0;
        m_words.delete();
        p1          = '0;
        p2          = '0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    // Drive one cycle of inputs, predict its effect, advance past the edge
    // and compare every output against the prediction.
    task automatic step(input bit wv, input logic [TW-1:0] wt, input logic [31:0] wd,
                        input bit wl, input bit rv, input logic [TW-1:0] rt,
                        input bit inv);
        rd_t   e;
        bit    rdy;
        bit    err;
        wide_t newrec;
        wr_valid  = wv;
        wr_tag    = wt;
        wr_data   = wd;
        wr_last   = wl;
        rd_valid  = rv;
        rd_tag    = rt;
        inv_start = inv;

        rdy = (m_busy_left == 0);
        chk("wr_ready", wide_t'(wr_ready), wide_t'(rdy));
        chk("rd_ready", wide_t'(rd_ready), wide_t'(rdy));
        chk("inv_busy", wide_t'(inv_busy), wide_t'(!rdy));

        e   = '0;
        err = 1'b0;
        if (rdy && rv) begin
            e.v   = 1'b1;
            e.hit = m_valid[rt];
            e.rec = m_rec[rt];
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (inv) begin
            m_inprog    = 1'b0;
            m_drop      = 1'b0;
            m_busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else if (wv) begin
            if (m_drop) begin
                if (wl) begin
                    m_drop   = 1'b0;
                    m_inprog = 1'b0;
                end
            end else begin
                if (!m_inprog) begin
                    m_inprog = 1'b1;
                    m_tag    = wt;
                    m_words.delete();
                    m_valid[wt] = 1'b0;
                end
                m_words.push_back(wd);
                if (wl) begin
                    if (m_words.size() == RW) begin
                        for (int k = 0; k < RW; k++) newrec[32*k +: 32] = m_words[k];
                        m_rec[m_tag]   = newrec;
                        m_valid[m_tag] = 1'b1;
`ifdef PCACHE_BYPASS_EN
                        if (e.v && rt == m_tag) begin
                            e.hit = 1'b1;
                            e.rec = newrec;
                        end
`endif
                    end else begin
                        err = 1'b1;
                    end
                    m_inprog = 1'b0;
                end else if (m_words.size() == RW) begin
                    err    = 1'b1;
                    m_drop = 1'b1;
                end
            end
        end

        @(posedge clock);
        #1;
        p2 = p1;
        p1 = e;
        chk("err_len", wide_t'(err_len), wide_t'(err));
        chk("rd_out_valid", wide_t'(rd_out_valid), wide_t'(p2.v));
        if (p2.v) begin
            chk("rd_hit", wide_t'(rd_hit), wide_t'(p2.hit));
            if (p2.hit) chk("rd_rec", rd_rec, p2.rec);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic send_rec(input logic [TW-1:0] t, input int len, input logic [31:0] base);
        for (int k = 0; k < len; k++) step(1, t, base + k, (k == len - 1), 0, '0, 0);
    endtask

    task automatic do_reset(input int n);
        reset_n   = 1'b0;
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        rd_valid  = 1'b0;
        inv_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
        chk("rst_rd_out_valid", wide_t'(rd_out_valid), '0);
        chk("rst_rd_hit", wide_t'(rd_hit), '0);
        chk("rst_rd_rec", rd_rec, '0);
        chk("rst_err_len", wide_t'(err_len), '0);
        chk("rst_inv_busy", wide_t'(inv_busy), wide_t'(1'b1));
        chk("rst_wr_ready", wide_t'(wr_ready), '0);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit            wv, rv, inv, adv;
        int            len, sel, k;
        logic [TW-1:0] tg;
        logic [31:0]   base;

        reset_n = 1'b0; wr_valid = 1'b0; wr_tag = '0; wr_data = '0; wr_last = 1'b0;
        rd_valid = 1'b0; rd_tag = '0; inv_start = 1'b0;

        // Reset then idle: 16-cycle sweep, then ready.
        do_reset(3);
        idle(DEPTH + 4);

        // Full record to tag 5 and read back.
        send_rec(4'd5, RW, 32'h100);
        step(0, '0, '0, 0, 1, 4'd5, 0);
        idle(3);

        // Short record to tag 7: err_len, then miss.
        send_rec(4'd7, 10, 32'h700);
        step(0, '0, '0, 0, 1, 4'd7, 0);
        idle(3);

        // Overrun record to tag 9 (30 words).
        send_rec(4'd9, 30, 32'h900);
        step(0, '0, '0, 0, 1, 4'd9, 0);
        idle(3);

        // Commit tag 3 while reading tag 3 in the same cycle.
        for (int i = 0; i < RW - 1; i++) step(1, 4'd3, 32'h300 + i, 0, 0, '0, 0);
        step(1, 4'd3, 32'h300 + RW - 1, 1, 1, 4'd3, 0);
        step(0, '0, '0, 0, 1, 4'd3, 0);
        idle(3);

        // Commit 1 and 2, abort the fill of 4 with inv_start, read back.
        send_rec(4'd1, RW, 32'h1000);
        send_rec(4'd2, RW, 32'h2000);
        for (int i = 0; i < 5; i++) step(1, 4'd4, 32'h4000 + i, 0, 0, '0, 0);
        step(1, 4'd4, 32'h4005, 0, 1, 4'd1, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        idle(DEPTH);
        step(0, '0, '0, 0, 1, 4'd1, 0);
        step(0, '0, '0, 0, 1, 4'd2, 0);
        step(0, '0, '0, 0, 1, 4'd4, 0);
        idle(3);

        // Every fourth slot committed, read all 16 back-to-back.
        for (int t = 0; t < DEPTH; t += 4) send_rec(TW'(t), RW, 32'hA000 + 32'(t) * 32'h100);
        for (int t = 0; t < DEPTH; t++) step(0, '0, '0, 0, 1, TW'(t), 0);
        idle(3);

        // Reset mid-fill of tag 8 (committed earlier) discards it.
        for (int i = 0; i < 12; i++) step(1, 4'd8, 32'h8800 + i, 0, 0, '0, 0);
        do_reset(2);
        idle(DEPTH);
        step(0, '0, '0, 0, 1, 4'd8, 0);
        step(0, '0, '0, 0, 1, 4'd0, 0);
        idle(3);

        // Randomized records with gaps, concurrent reads and rare invalidates.
        for (int r = 0; r < 60; r++) begin
            sel  = int'($urandom_range(0, 9));
            if (sel < 6)      len = RW;
            else if (sel < 8) len = int'($urandom_range(1, RW - 1));
            else              len = int'($urandom_range(RW + 1, RW + 4));
            tg   = TW'($urandom_range(0, DEPTH - 1));
            base = $urandom;
            k    = 0;
            while (k < len) begin
                wv  = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 1) != 0);
                inv = ($urandom_range(0, 299) == 0);
                adv = (m_busy_left == 0) && wv;
                step(wv, tg, base + 32'(k), (k == len - 1), rv, TW'($urandom_range(0, DEPTH - 1)), inv);
                if (adv) k++;
            end
        end
        for (int t = 0; t < DEPTH; t++) step(0, '0, '0, 0, 1, TW'(t), 0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prim_param_cache
`default_nettype wire
